// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator, MSB first.
// Reuses the 1-bit comparator stage per clock.

module comparator1bit (
   input  logic a,
   input  logic b,
   output logic gt,
   output logic eq,
   output logic lt
);

   assign gt = a & ~b;
   assign eq = ~(a ^ b);
   assign lt = ~a & b;

endmodule

module serial_mag_comparator #(
   parameter int WIDTH      = 8,
   parameter int EARLY_EXIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [CW-1:0]    cnt;
   logic             decided;
   logic             pend_gt;
   logic             bit_gt;
   logic             bit_eq;
   logic             bit_lt;
   logic             fin;
   logic             accept;
   logic             res_gt;
   logic             res_lt;

   comparator1bit u_cmp (
      .a  (sa[WIDTH-1]),
      .b  (sb[WIDTH-1]),
      .gt (bit_gt),
      .eq (bit_eq),
      .lt (bit_lt)
   );

   assign accept = (state == IDLE) && start;
   assign fin    = (state == SHIFT) &&
                   (((EARLY_EXIT != 0) && !bit_eq) ||
                    (cnt == '0));

   // The first differing bit wins; the current bit only
   // counts when nothing has been decided yet.
   assign res_gt = decided ? pend_gt : bit_gt;
   assign res_lt = decided ? ~pend_gt : bit_lt;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (start) state_nxt = SHIFT;
         SHIFT: if (fin)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode.
   always_comb begin
      busy = (state == SHIFT);
   end

   // Operand shift, bit counter and first-decision capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa      <= '0;
         sb      <= '0;
         cnt     <= '0;
         decided <= 1'b0;
         pend_gt <= 1'b0;
      end else if (accept) begin
         sa      <= a_in;
         sb      <= b_in;
         cnt     <= CW'(WIDTH - 1);
         decided <= 1'b0;
         pend_gt <= 1'b0;
      end else if (state == SHIFT) begin
         sa <= {sa[WIDTH-2:0], 1'b0};
         sb <= {sb[WIDTH-2:0], 1'b0};
         if (cnt != '0) cnt <= cnt - 1'b1;
         if (!decided && !bit_eq) begin
            decided <= 1'b1;
            pend_gt <= bit_gt;
         end
      end
   end

   // Completion pulse and held word-level result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done <= 1'b0;
         gt   <= 1'b0;
         eq   <= 1'b0;
         lt   <= 1'b0;
      end else begin
         done <= fin;
         if (fin) begin
            gt <= res_gt;
            lt <= res_lt;
            eq <= ~res_gt & ~res_lt;
         end
      end
   end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Bench for serial_mag_comparator, WIDTH=8.
// Runs EARLY_EXIT=1 and EARLY_EXIT=0 instances side by side.

module tb_serial_mag_comparator;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] a_in = '0;
   logic [7:0] b_in = '0;

   logic busy1, done1, gt1, eq1, lt1;
   logic busy0, done0, gt0, eq0, lt0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a_in  (a_in),
      .b_in  (b_in),
      .busy  (busy1),
      .done  (done1),
      .gt    (gt1),
      .eq    (eq1),
      .lt    (lt1)
   );

   serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a_in  (a_in),
      .b_in  (b_in),
      .busy  (busy0),
      .done  (done0),
      .gt    (gt0),
      .eq    (eq0),
      .lt    (lt0)
   );

   // Transaction-level model: a run lasts n edges, result is
   // the plain arithmetic comparison of the captured operands.
   typedef struct {
      logic       busy;
      logic       done;
      logic [2:0] res;
      logic [2:0] pend;
      int         left;
   } m_t;

   m_t m1 = '{1'b0, 1'b0, 3'b000, 3'b000, 0};
   m_t m0 = '{1'b0, 1'b0, 3'b000, 3'b000, 0};

   function automatic int bits_needed(logic [7:0] a, logic [7:0] b,
                                      bit ee);
      if (!ee || a == b) return 8;
      for (int i = 7; i >= 0; i--)
         if (a[i] != b[i]) return 8 - i;
      return 8;
   endfunction

   function automatic m_t step(m_t m, logic s, logic [7:0] a,
                               logic [7:0] b, bit ee);
      m_t r = m;
      r.done = 1'b0;
      if (m.busy) begin
         r.left = m.left - 1;
         if (r.left == 0) begin
            r.busy = 1'b0;
            r.done = 1'b1;
            r.res  = m.pend;
         end
      end else if (s) begin
         r.busy = 1'b1;
         r.left = bits_needed(a, b, ee);
         r.pend = {a > b, a == b, a < b};
      end
      return r;
   endfunction

   // Model advance on every active edge, cleared by async reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m1 = '{1'b0, 1'b0, 3'b000, 3'b000, 0};
         m0 = '{1'b0, 1'b0, 3'b000, 3'b000, 0};
      end else begin
         m1 = step(m1, start, a_in, b_in, 1'b1);
         m0 = step(m0, start, a_in, b_in, 1'b0);
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      chk("cyc_ee1", {27'd0, busy1, done1, gt1, eq1, lt1},
          {27'd0, m1.busy, m1.done, m1.res});
      chk("cyc_ee0", {27'd0, busy0, done0, gt0, eq0, lt0},
          {27'd0, m0.busy, m0.done, m0.res});
   end

   // One run on both instances; pins latency and result literally.
   task automatic run_pair(string nm, logic [7:0] a, logic [7:0] b,
                           int c1, int c0, logic [2:0] res);
      bit f1 = 0;
      bit f0 = 0;
      @(negedge clk);
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k <= 20 && !(f1 && f0); k++) begin
         if (done1 && !f1) begin
            f1 = 1;
            chk({nm, "_lat1"}, k, c1);
            chk({nm, "_res1"}, {gt1, eq1, lt1}, res);
         end
         if (done0 && !f0) begin
            f0 = 1;
            chk({nm, "_lat0"}, k, c0);
            chk({nm, "_res0"}, {gt0, eq0, lt0}, res);
         end
         if (!(f1 && f0)) @(negedge clk);
      end
      chk({nm, "_timeout"}, {30'd0, f1, f0}, 32'd3);
   endtask

   initial begin
      int d1[$];
      int d0[$];
      #2;
      chk("reset_out1", {busy1, done1, gt1, eq1, lt1}, 0);
      chk("reset_out0", {busy0, done0, gt0, eq0, lt0}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_pair("t1_eq", 8'hA5, 8'hA5, 8, 8, 3'b010);
      run_pair("t2_gt", 8'h80, 8'h7F, 1, 8, 3'b100);
      run_pair("t3_lt", 8'h12, 8'h13, 8, 8, 3'b001);
      run_pair("t3_lt2", 8'h3C, 8'h4C, 2, 8, 3'b001);

      // Held start with operand change while busy.
      @(negedge clk);
      a_in  = 8'h01;
      b_in  = 8'h00;
      start = 1'b1;
      @(negedge clk);
      for (int k = 0; k <= 20; k++) begin
         if (k == 2) a_in = 8'hFF;
         if (k == 9) start = 1'b0;
         if (done1) begin
            d1.push_back(k);
            chk("t4_res1", {gt1, eq1, lt1}, 3'b100);
         end
         if (done0) begin
            d0.push_back(k);
            chk("t4_res0", {gt0, eq0, lt0}, 3'b100);
         end
         @(negedge clk);
      end
      chk("t4_n1", d1.size(), 2);
      chk("t4_n0", d0.size(), 2);
      if (d1.size() == 2) begin
         chk("t4_d1a", d1[0], 8);
         chk("t4_d1b", d1[1], 10);
      end
      if (d0.size() == 2) begin
         chk("t4_d0a", d0[0], 8);
         chk("t4_d0b", d0[1], 17);
      end

      // Reset in the third cycle of an 8-cycle compare.
      @(negedge clk);
      a_in  = 8'h55;
      b_in  = 8'h55;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t5_rst1", {busy1, done1, gt1, eq1, lt1}, 0);
      chk("t5_rst0", {busy0, done0, gt0, eq0, lt0}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_idle1", {busy1, done1, gt1, eq1, lt1}, 0);
      run_pair("t5_lt", 8'h00, 8'hFF, 1, 8, 3'b001);

      run_pair("t6_eq", 8'h5A, 8'h5A, 8, 8, 3'b010);
      repeat (3) @(negedge clk);
      chk("t6_hold_eq", {gt1, eq1, lt1}, 3'b010);
      run_pair("t6_gt", 8'hC0, 8'h40, 1, 8, 3'b100);
      repeat (3) @(negedge clk);
      chk("t6_hold_gt", {gt0, eq0, lt0}, 3'b100);
      run_pair("t6_lt", 8'h0F, 8'h10, 4, 8, 3'b001);
      repeat (3) @(negedge clk);
      chk("t6_hold_lt", {gt1, eq1, lt1}, 3'b001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
